vram_wr_arbiter: RTL and testbench

//  Shares the single VRAM write port among NUM_REQ writers (clear/fill engine, glyph blitter, UART poke) on clk.

---
 rtl/vram_pkg.sv | 13 +
 rtl/vram_wr_arbiter_if.sv | 27 ++
 rtl/vram_wr_arbiter_rr_pick.sv | 22 ++
 rtl/vram_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_wr_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - framebuffer geometry constants and arbiter state encoding
package vram_pkg;
  localparam int VRAM_WIDTH  = 160;
  localparam int VRAM_HEIGHT = 90;
  localparam int VRAM_SIZE   = VRAM_WIDTH * VRAM_HEIGHT;
  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 24;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;
endpackage

// File: rtl/vram_wr_arbiter_if.sv
// rtl/vram_wr_arbiter_if.sv - requester beat bus and registered VRAM write port
interface vram_wr_arbiter_if
  import vram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int DATA_W  = VRAM_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      vram_we;
  logic [ADDR_W-1:0]         vram_addr;
  logic [DATA_W-1:0]         vram_wdata;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready, vram_we, vram_addr, vram_wdata
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready, vram_we, vram_addr, vram_wdata
  );
endinterface

// File: rtl/vram_wr_arbiter_rr_pick.sv
// rtl/vram_wr_arbiter_rr_pick.sv - combinational round-robin picker
// Returns the first set request found scanning ptr, ptr+1, ... mod NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);
  always_comb begin
    any = |req;
    idx = '0;
    // Scan from the farthest slot back to ptr so the nearest one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/vram_wr_arbiter.sv
// rtl/vram_wr_arbiter.sv - round-robin burst arbiter for the single VRAM write port
// Optional macro VRAM_ARB_VBLANK_GATE_EN: new grants only while vblank=1.
module vram_wr_arbiter #(
  parameter  int NUM_REQ   = 3,
  parameter  int ADDR_W    = vram_pkg::VRAM_ADDR_W,
  parameter  int DATA_W    = vram_pkg::VRAM_DATA_W,
  parameter  int VRAM_SIZE = vram_pkg::VRAM_SIZE,
  parameter  int MAX_BURST = 16,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  vram_wr_arbiter_if.slave    bus,
  input  logic                vblank,
  output logic [IDX_W-1:0]    grant_id,
  output logic                busy,
  output logic [15:0]         oob_cnt
);
  import vram_pkg::*;

  localparam logic [ADDR_W:0] SIZE_LIM = (ADDR_W + 1)'(VRAM_SIZE);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d, beat_inc;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       oob_q, oob_d;

  logic              gate_open;
  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              sel_valid, sel_last, in_range, rel_burst;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef VRAM_ARB_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_open     = 1'b1;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign sel_valid = bus.req_valid[grant_id_q];
  assign sel_last  = bus.req_last[grant_id_q];
  assign sel_addr  = bus.req_addr[int'(grant_id_q) * ADDR_W +: ADDR_W];
  assign sel_data  = bus.req_data[int'(grant_id_q) * DATA_W +: DATA_W];
  assign in_range  = ({1'b0, sel_addr} < SIZE_LIM);
  assign beat_inc  = beat_cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    oob_d         = oob_q;
    rel_burst     = 1'b0;
    bus.req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (gate_open && pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        bus.req_ready[grant_id_q] = 1'b1;
        if (sel_valid) begin
          beat_cnt_d = beat_inc;
          if (in_range) begin
            we_d    = 1'b1;
            addr_d  = sel_addr;
            wdata_d = sel_data;
          end else if (oob_q != 16'hFFFF) begin
            oob_d = oob_q + 16'd1;
          end
        end
        // A requester dropping valid mid-burst gives the port up immediately.
        rel_burst = !sel_valid || sel_last || (beat_inc == CNT_W'(MAX_BURST));
        if (rel_burst) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oob_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oob_q      <= oob_d;
    end
  end

  assign bus.vram_we    = we_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_wdata = wdata_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q == ST_BURST);
  assign oob_cnt        = oob_q;
endmodule

// File: tb/tb_vram_wr_arbiter.sv
// tb/tb_vram_wr_arbiter.sv - randomized bench with transaction-level arbitration model
module tb_vram_wr_arbiter;
  localparam int N = 3, AW = 14, DW = 24, SIZE = 14400, MB = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] oob_cnt;

  vram_wr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_wr_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .VRAM_SIZE(SIZE), .MAX_BURST(MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .vblank   (vblank),
    .grant_id (grant_id),
    .busy     (busy),
    .oob_cnt  (oob_cnt)
  );

  always #5 clk = ~clk;

  int n_tests, n_fail;
  beat_t rq [N][$];
  logic [AW+DW-1:0] obs_w[$], exp_w[$];
  int obs_g[$], exp_g[$], obs_gcyc[$], obs_wcyc[$];
  int exp_oob;

  function automatic void push_beat(int r, int addr, bit last);
    beat_t b;
    b.addr = AW'(addr);
    b.data = DW'($urandom);
    b.last = last;
    rq[r].push_back(b);
  endfunction

  task automatic drive_valids();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_last[i]           = rq[i][0].last;
        bus.req_addr[i*AW +: AW]  = rq[i][0].addr;
        bus.req_data[i*DW +: DW]  = rq[i][0].data;
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_last[i]           = 1'b0;
        bus.req_addr[i*AW +: AW]  = '0;
        bus.req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vblank = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive_valids();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Grant-level model: each grant takes beats until last, MAX_BURST, or the requester runs dry.
  task automatic model_run();
    beat_t m [N][$];
    beat_t b;
    int rr, pick, n;
    for (int i = 0; i < N; i++) m[i] = rq[i];
    exp_w.delete(); exp_g.delete(); exp_oob = 0; rr = 0;
    while (1) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && m[(rr + k) % N].size() > 0) pick = (rr + k) % N;
      if (pick < 0) break;
      exp_g.push_back(pick);
      n = 0;
      do begin
        b = m[pick].pop_front();
        n++;
        if (int'(b.addr) < SIZE) exp_w.push_back({b.addr, b.data});
        else exp_oob++;
      end while (!b.last && n < MB && m[pick].size() > 0);
      rr = (pick + 1) % N;
    end
  endtask

  task automatic run_traffic(input int budget);
    int cyc, left;
    bit done, prev_busy;
    bit acc [N];
    obs_w.delete(); obs_g.delete(); obs_gcyc.delete(); obs_wcyc.delete();
    drive_valids();
    prev_busy = busy;
    cyc = 0; done = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      if (bus.vram_we) begin
        obs_w.push_back({bus.vram_addr, bus.vram_wdata});
        obs_wcyc.push_back(cyc);
      end
      if (busy && !prev_busy) begin
        obs_g.push_back(int'(grant_id));
        obs_gcyc.push_back(cyc);
      end
      prev_busy = busy;
      left = 0;
      for (int i = 0; i < N; i++) begin
        acc[i] = bus.req_valid[i] && bus.req_ready[i];
        left += rq[i].size();
      end
      done = (left == 0) && !busy && !bus.vram_we;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
      drive_valids();
      cyc++;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL traffic_timeout: completed=%0d required=1", done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.vram_we, busy, grant_id, oob_cnt, bus.req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b busy=%b gid=%0d oob=%0d ready=%b required all 0",
               bus.vram_we, busy, grant_id, oob_cnt, bus.req_ready);
    end
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_beat(0, i, i == 3);
      d[i] = rq[0][i].data;
    end
    run_traffic(40);
    n_tests++;
    if (obs_g.size() != 1 || obs_gcyc[0] != 1 || obs_g[0] != 0) begin
      n_fail++;
      $display("FAIL single_grant: grants=%0d first_cyc=%0d required 1 grant of req0 at cycle 1",
               obs_g.size(), (obs_gcyc.size() > 0) ? obs_gcyc[0] : -1);
    end
    n_tests++;
    if (obs_w.size() != 4) begin
      n_fail++;
      $display("FAIL single_write_count: got %0d required 4", obs_w.size());
    end
    for (int k = 0; k < obs_w.size() && k < 4; k++) begin
      n_tests++;
      if (obs_w[k] !== {AW'(k), d[k]} || obs_wcyc[k] != k + 2) begin
        n_fail++;
        $display("FAIL single_write[%0d]: got %h at cycle %0d required %h at cycle %0d",
                 k, obs_w[k], obs_wcyc[k], {AW'(k), d[k]}, k + 2);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < N; r++) push_beat(r, $urandom_range(0, SIZE - 1), 1'b1);
    model_run();
    run_traffic(80);
    n_tests++;
    if (obs_g.size() != 9) begin
      n_fail++;
      $display("FAIL rr_grant_count: got %0d required 9", obs_g.size());
    end
    for (int k = 0; k < obs_g.size() && k < 9; k++) begin
      n_tests++;
      if (obs_g[k] != k % N || obs_gcyc[k] != 1 + 2 * k) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got req%0d at cycle %0d required req%0d at cycle %0d",
                 k, obs_g[k], obs_gcyc[k], k % N, 1 + 2 * k);
      end
    end
    n_tests++;
    if (obs_w != exp_w) begin
      n_fail++;
      $display("FAIL rr_writes: got %0d writes required %0d matching writes", obs_w.size(), exp_w.size());
    end
  endtask

  task automatic test_burst_limit();
    do_reset();
    for (int i = 0; i < 40; i++) push_beat(1, 100 + i, 1'b0);
    push_beat(2, 7, 1'b0);
    push_beat(2, 8, 1'b1);
    model_run();
    run_traffic(200);
    n_tests++;
    if (obs_g.size() != 4 || obs_g[0] != 1 || obs_g[1] != 2 || obs_g[2] != 1 || obs_g[3] != 1) begin
      n_fail++;
      $display("FAIL limit_grants: got %0d grants required sequence 1,2,1,1", obs_g.size());
    end
    n_tests++;
    if (obs_gcyc.size() < 2 || obs_gcyc[1] != 18) begin
      n_fail++;
      $display("FAIL limit_release: second grant cycle %0d required 18",
               (obs_gcyc.size() > 1) ? obs_gcyc[1] : -1);
    end
    n_tests++;
    if (obs_w != exp_w || obs_w.size() != 42) begin
      n_fail++;
      $display("FAIL limit_writes: got %0d writes required 42 matching writes", obs_w.size());
    end
  endtask

  task automatic test_oob();
    logic [DW-1:0] d0;
    do_reset();
    push_beat(0, SIZE - 1, 1'b0);
    push_beat(0, SIZE, 1'b1);
    d0 = rq[0][0].data;
    run_traffic(30);
    n_tests++;
    if (obs_w.size() != 1 || obs_w[0] !== {AW'(SIZE - 1), d0}) begin
      n_fail++;
      $display("FAIL oob_write: got %0d writes required exactly one write to %0d", obs_w.size(), SIZE - 1);
    end
    n_tests++;
    if (oob_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL oob_count: got %0d required 1", oob_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    bit acc;
    do_reset();
    push_beat(2, SIZE + 5, 1'b0);
    push_beat(2, 16383, 1'b0);
    for (int i = 0; i < 30; i++) push_beat(2, i, 1'b0);
    drive_valids();
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 5; c++) begin
      @(negedge clk);
      acc = bus.req_valid[2] && bus.req_ready[2];
      @(posedge clk);
      #1;
      if (acc) begin
        void'(rq[2].pop_front());
        cnt++;
      end
      drive_valids();
    end
    @(negedge clk);
    n_tests++;
    if (cnt != 5 || busy !== 1'b1 || grant_id !== 2'd2 || oob_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL midburst_pre: beats=%0d busy=%b gid=%0d oob=%0d required 5,1,2,2",
               cnt, busy, grant_id, oob_cnt);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.vram_we !== 1'b0 || bus.req_ready !== 3'b000 || busy !== 1'b0 ||
        grant_id !== 2'd0 || oob_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midburst_reset: we=%b ready=%b busy=%b gid=%0d oob=%0d required all 0",
               bus.vram_we, bus.req_ready, busy, grant_id, oob_cnt);
    end
    do_reset();
  endtask

  task automatic test_vblank();
    bit seen;
    do_reset();
    vblank = 1'b0;
    push_beat(0, 42, 1'b1);
    drive_valids();
`ifdef VRAM_ARB_VBLANK_GATE_EN
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) seen = 1;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL vblank_hold: granted=%0d required 0", seen);
    end
    vblank = 1'b1;
    @(negedge clk);
    seen = busy;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (seen || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL vblank_grant: busy %b then %b required 0 then 1", seen, busy);
    end
`else
    @(negedge clk);
    seen = busy;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (seen || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL vblank_ignored: busy %b then %b required 0 then 1", seen, busy);
    end
`endif
    do_reset();
  endtask

  task automatic test_random();
    int cnt, a;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int r = 0; r < N; r++) begin
        cnt = $urandom_range(0, 24);
        for (int i = 0; i < cnt; i++) begin
          case ($urandom_range(0, 7))
            0:       a = $urandom_range(SIZE, 16383);
            1:       a = SIZE - 1;
            2:       a = SIZE;
            default: a = $urandom_range(0, SIZE - 1);
          endcase
          push_beat(r, a, $urandom_range(0, 5) == 0);
        end
      end
      model_run();
      run_traffic(400);
      n_tests++;
      if (obs_g != exp_g) begin
        n_fail++;
        $display("FAIL rand_grants[%0d]: got %0d grants required %0d matching grants",
                 it, obs_g.size(), exp_g.size());
      end
      n_tests++;
      if (obs_w.size() != exp_w.size()) begin
        n_fail++;
        $display("FAIL rand_write_count[%0d]: got %0d required %0d", it, obs_w.size(), exp_w.size());
      end
      for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++) begin
        n_tests++;
        if (obs_w[k] !== exp_w[k]) begin
          n_fail++;
          $display("FAIL rand_write[%0d.%0d]: got %h required %h", it, k, obs_w[k], exp_w[k]);
        end
      end
      n_tests++;
      if (int'(oob_cnt) != exp_oob) begin
        n_fail++;
        $display("FAIL rand_oob[%0d]: got %0d required %0d", it, oob_cnt, exp_oob);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    vblank  = 1'b1;
    drive_valids();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_burst_limit();
    test_oob();
    test_reset_mid_burst();
    test_vblank();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
